// File: rtl/axi_slave_mem.sv
// AXI4 burst slave backed by a word-addressed memory; independent write and read FSMs.
// Optional macro AXI_SLAVE_MEM_ERR_RESP_EN enables SLVERR for out-of-range/wlast errors.
module axi_slave_mem #(
    parameter int MEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready
);
    // Every channel transfers on the cycle where valid && ready are both high at the rising edge;
    // a source holds valid and its payload stable until that transfer.
    localparam int          AW          = $clog2(MEM_DEPTH);
    localparam logic [31:0] DEPTH_WORDS = 32'(MEM_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t    w_state;
    r_state_t    r_state;
    logic [31:0] mem [MEM_DEPTH];
    logic [31:0] waddr, raddr, raddr_next, rd_addr, rd_word;
    logic [7:0]  wlen, wcnt, rlen, rcnt;
    logic        werr;
    logic        aw_oor, ar_oor, w_beat_oor, rd_oor, wlast_err;
    logic        w_fire, w_final, w_wr_en;
    logic [AW-1:0] w_idx, rd_idx;
    logic        unused_inputs;

    assign w_fire     = (w_state == W_DATA) && wvalid && wready;
    assign w_final    = (wcnt == wlen);
    assign w_idx      = waddr[AW+1:2];
    assign raddr_next = raddr + 32'd4;
    // The next word to present is fetched one edge early so rdata is a register.
    assign rd_addr    = (r_state == R_IDLE) ? araddr : raddr_next;
    assign rd_idx     = rd_addr[AW+1:2];

`ifdef AXI_SLAVE_MEM_ERR_RESP_EN
    assign aw_oor     = ({2'b00, awaddr[31:2]} + {24'd0, awlen}) >= DEPTH_WORDS;
    assign ar_oor     = ({2'b00, araddr[31:2]} + {24'd0, arlen}) >= DEPTH_WORDS;
    assign w_beat_oor = {2'b00, waddr[31:2]} >= DEPTH_WORDS;
    assign rd_oor     = {2'b00, rd_addr[31:2]} >= DEPTH_WORDS;
    assign wlast_err  = (wlast != w_final);
`else
    assign aw_oor     = 1'b0;
    assign ar_oor     = 1'b0;
    assign w_beat_oor = 1'b0;
    assign rd_oor     = 1'b0;
    assign wlast_err  = 1'b0;
`endif

    assign w_wr_en       = w_fire && !w_beat_oor && !reset;
    assign rd_word       = rd_oor ? 32'd0 : mem[rd_idx];
    assign unused_inputs = ^{awsize, awburst, arsize, arburst, awaddr, araddr, wlast, waddr, rd_addr};

    // No reset: contents survive reset; a beat coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state <= W_IDLE;
            awready <= 1'b1;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
            waddr   <= 32'd0;
            wlen    <= 8'd0;
            wcnt    <= 8'd0;
            werr    <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (awvalid) begin
                    waddr   <= awaddr;
                    wlen    <= awlen;
                    wcnt    <= 8'd0;
                    werr    <= aw_oor;
                    awready <= 1'b0;
                    wready  <= 1'b1;
                    w_state <= W_DATA;
                end
                W_DATA: if (w_fire) begin
                    waddr <= waddr + 32'd4;
                    wcnt  <= wcnt + 8'd1;
                    werr  <= werr | wlast_err;
                    // Burst length comes from the beat counter; wlast only feeds the error flag.
                    if (w_final) begin
                        wready  <= 1'b0;
                        bvalid  <= 1'b1;
                        bresp   <= (werr || wlast_err) ? 2'b10 : 2'b00;
                        w_state <= W_RESP;
                    end
                end
                W_RESP: if (bready) begin
                    bvalid  <= 1'b0;
                    bresp   <= 2'b00;
                    awready <= 1'b1;
                    w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= R_IDLE;
            arready <= 1'b1;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rresp   <= 2'b00;
            rdata   <= 32'd0;
            raddr   <= 32'd0;
            rlen    <= 8'd0;
            rcnt    <= 8'd0;
        end else begin
            case (r_state)
                R_IDLE: if (arvalid) begin
                    raddr   <= araddr;
                    rlen    <= arlen;
                    rcnt    <= 8'd0;
                    rdata   <= rd_word;
                    rlast   <= (arlen == 8'd0);
                    rresp   <= ar_oor ? 2'b10 : 2'b00;
                    rvalid  <= 1'b1;
                    arready <= 1'b0;
                    r_state <= R_DATA;
                end
                R_DATA: if (rready) begin
                    if (rlast) begin
                        rvalid  <= 1'b0;
                        rlast   <= 1'b0;
                        rresp   <= 2'b00;
                        arready <= 1'b1;
                        r_state <= R_IDLE;
                    end else begin
                        raddr <= raddr_next;
                        rcnt  <= rcnt + 8'd1;
                        rdata <= rd_word;
                        rlast <= ((rcnt + 8'd1) == rlen);
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_slave_mem.sv
// Self-checking bench for axi_slave_mem: randomized bursts against a word-array reference model.
// Follows AXI_SLAVE_MEM_ERR_RESP_EN when it is defined for the build.
module tb_axi_slave_mem;
    localparam int MEM_DEPTH = 256;
    localparam int TO        = 64;
`ifdef AXI_SLAVE_MEM_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    logic [31:0] model_mem [MEM_DEPTH];
    logic [31:0] wbuf_data [256];
    logic [3:0]  wbuf_strb [256];
    int n_checks = 0;
    int n_fail   = 0;

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    axi_slave_mem #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clk(clk), .reset(reset),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // driver tasks (entered and left on a falling edge)
    task automatic send_aw(input logic [31:0] addr, input logic [7:0] len);
        int t;
        awaddr  = addr;
        awlen   = len;
        awsize  = 3'($urandom_range(0, 7));
        awburst = 2'($urandom_range(0, 3));
        awvalid = 1'b1;
        t = 0;
        while (awready !== 1'b1 && t < TO) begin @(negedge clk); t++; end
        n_checks++;
        if (awready !== 1'b1) begin
            n_fail++;
            $display("FAIL aw_handshake: awready=%b, required 1 within %0d cycles", awready, TO);
        end
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] addr, input logic [7:0] len);
        int t;
        araddr  = addr;
        arlen   = len;
        arsize  = 3'($urandom_range(0, 7));
        arburst = 2'($urandom_range(0, 3));
        arvalid = 1'b1;
        t = 0;
        while (arready !== 1'b1 && t < TO) begin @(negedge clk); t++; end
        n_checks++;
        if (arready !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_handshake: arready=%b, required 1 within %0d cycles", arready, TO);
        end
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    // Write burst of len+1 beats from wbuf_*; the model is updated as each beat is accepted.
    task automatic do_write(input logic [31:0] addr, input int len, input bit bad_wlast,
                            input int b_delay);
        logic [1:0] exp_resp;
        longint     base, w;
        int         t;
        exp_resp = 2'b00;
        base     = longint'(addr >> 2);
        send_aw(addr, 8'(len));
        for (int i = 0; i <= len; i++) begin
            if ($urandom_range(0, 3) == 0) begin wvalid = 1'b0; @(negedge clk); end
            wdata  = wbuf_data[i];
            wstrb  = wbuf_strb[i];
            wlast  = bad_wlast ? 1'b0 : (i == len);
            wvalid = 1'b1;
            t = 0;
            while (wready !== 1'b1 && t < TO) begin @(negedge clk); t++; end
            n_checks++;
            if (wready !== 1'b1) begin
                n_fail++;
                $display("FAIL w_beat: beat %0d wready=%b, required 1", i, wready);
                break;
            end
            w = base + i;
            if (ERR_EN && w >= MEM_DEPTH) exp_resp = 2'b10;
            else model_mem[w % MEM_DEPTH] = merge(model_mem[w % MEM_DEPTH], wbuf_data[i], wbuf_strb[i]);
            @(negedge clk);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        if (ERR_EN && bad_wlast) exp_resp = 2'b10;
        bready = 1'b0;
        t = 0;
        while (bvalid !== 1'b1 && t < TO) begin @(negedge clk); t++; end
        n_checks++;
        if (bvalid !== 1'b1 || bresp !== exp_resp) begin
            n_fail++;
            $display("FAIL b_resp: addr %h bvalid=%b bresp=%b, required bvalid=1 bresp=%b",
                     addr, bvalid, bresp, exp_resp);
        end
        for (int d = 0; d < b_delay; d++) begin
            @(negedge clk);
            n_checks++;
            if (bvalid !== 1'b1 || bresp !== exp_resp || awready !== 1'b0) begin
                n_fail++;
                $display("FAIL b_hold: cycle %0d bvalid=%b bresp=%b awready=%b, required 1 %b 0",
                         d, bvalid, bresp, awready, exp_resp);
            end
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        n_checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1) begin
            n_fail++;
            $display("FAIL b_done: bvalid=%b awready=%b, required 0 1", bvalid, awready);
        end
    endtask

    // stall_mode 0: rready always 1; 1: pattern 1,0,0,1; 2: random
    task automatic do_read(input logic [31:0] addr, input int len, input int stall_mode);
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
        longint      base, w;
        int          beat, cyc;
        base     = longint'(addr >> 2);
        exp_resp = 2'b00;
        for (int i = 0; i <= len; i++) if (ERR_EN && base + i >= MEM_DEPTH) exp_resp = 2'b10;
        send_ar(addr, 8'(len));
        beat = 0;
        cyc  = 0;
        while (beat <= len && cyc < 2000) begin
            case (stall_mode)
                0:       rready = 1'b1;
                1:       rready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rready = 1'($urandom_range(0, 1));
            endcase
            w        = base + beat;
            exp_data = (ERR_EN && w >= MEM_DEPTH) ? 32'd0 : model_mem[w % MEM_DEPTH];
            n_checks++;
            if (rvalid !== 1'b1 || rdata !== exp_data || rlast !== (beat == len) || rresp !== exp_resp) begin
                n_fail++;
                $display("FAIL r_beat: addr %h beat %0d got rvalid=%b rdata=%h rlast=%b rresp=%b, required 1 %h %b %b",
                         addr, beat, rvalid, rdata, rlast, rresp, exp_data, beat == len, exp_resp);
            end
            if (rvalid === 1'b1 && rready) beat++;
            cyc++;
            @(negedge clk);
        end
        rready = 1'b0;
        n_checks++;
        if (beat <= len) begin
            n_fail++;
            $display("FAIL r_timeout: beats accepted %0d, required %0d", beat, len + 1);
        end
        n_checks++;
        if (rvalid !== 1'b0 || rlast !== 1'b0 || arready !== 1'b1) begin
            n_fail++;
            $display("FAIL r_done: rvalid=%b rlast=%b arready=%b, required 0 0 1", rvalid, rlast, arready);
        end
    endtask

    // scenarios
    task automatic test_reset();
        reset = 1'b1;
        awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({awready, arready, wready, bvalid, bresp, rvalid, rlast, rresp} !== 10'b11_0_0_00_0_0_00) begin
            n_fail++;
            $display("FAIL reset_state: got %b, required 1100000000",
                     {awready, arready, wready, bvalid, bresp, rvalid, rlast, rresp});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({awready, arready, wready, bvalid, bresp, rvalid, rlast, rresp} !== 10'b11_0_0_00_0_0_00) begin
            n_fail++;
            $display("FAIL idle_state: got %b, required 1100000000",
                     {awready, arready, wready, bvalid, bresp, rvalid, rlast, rresp});
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 256; i++) begin wbuf_data[i] = $urandom; wbuf_strb[i] = 4'hF; end
        do_write(32'h0, MEM_DEPTH - 1, 1'b0, 0);
        do_read(32'h0, 31, 0);
        do_read(32'h380, 31, 2);
    endtask

    task automatic test_incr_burst();
        for (int i = 0; i < 4; i++) begin wbuf_data[i] = 32'hA0 + i; wbuf_strb[i] = 4'hF; end
        do_write(32'h10, 3, 1'b0, 0);
        do_read(32'h10, 3, 0);
    endtask

    task automatic test_strobe();
        wbuf_data[0] = 32'h12345678; wbuf_strb[0] = 4'hF;
        do_write(32'h0, 0, 1'b0, 0);
        wbuf_data[0] = 32'hFFFFFFFF; wbuf_strb[0] = 4'b0101;
        do_write(32'h0, 0, 1'b0, 0);
        do_read(32'h0, 0, 0);
        n_checks++;
        if (model_mem[0] !== 32'h12FF56FF) begin
            n_fail++;
            $display("FAIL strobe_model: model word0=%h, required 12FF56FF", model_mem[0]);
        end
    endtask

    task automatic test_read_stall();
        do_read(32'h10, 3, 1);
        do_read(32'h40, 7, 1);
    endtask

    task automatic test_wrap();
        wbuf_data[0] = 32'h5A5A0001; wbuf_data[1] = 32'hC3C30002;
        wbuf_strb[0] = 4'hF;         wbuf_strb[1] = 4'hF;
        do_write(32'h3FC, 1, 1'b0, 0);
        do_read(32'h0, 0, 0);
        do_read(32'h3FC, 1, 0);
    endtask

    task automatic test_reset_mid_burst();
        for (int i = 0; i < 4; i++) wbuf_data[i] = $urandom;
        send_aw(32'h80, 8'd3);
        wdata = wbuf_data[0]; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
        @(negedge clk);
        model_mem[32] = wbuf_data[0];
        wdata = wbuf_data[1];
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        wvalid = 1'b0;
        n_checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abandon: bvalid=%b awready=%b wready=%b, required 0 1 0", bvalid, awready, wready);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (bvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_resp: bvalid=%b, required 0", bvalid);
        end
        do_read(32'h80, 3, 0);
    endtask

    task automatic test_bresp_hold();
        for (int i = 0; i < 3; i++) begin wbuf_data[i] = $urandom; wbuf_strb[i] = 4'hF; end
        do_write(32'h200, 2, 1'b0, 5);
        do_read(32'h200, 2, 0);
    endtask

    task automatic test_same_word();
        logic [31:0] old_w, new_w;
        old_w = model_mem[16];
        new_w = ~old_w;
        send_aw(32'h40, 8'd0);
        n_checks++;
        if (wready !== 1'b1 || arready !== 1'b1) begin
            n_fail++;
            $display("FAIL same_word_ready: wready=%b arready=%b, required 1 1", wready, arready);
        end
        wdata = new_w; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        araddr = 32'h40; arlen = 8'd0; arvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        model_mem[16] = new_w;
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== old_w || rlast !== 1'b1 || bvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL same_word_read: rvalid=%b rdata=%h rlast=%b bvalid=%b, required 1 %h 1 1",
                     rvalid, rdata, rlast, bvalid, old_w);
        end
        rready = 1'b1; bready = 1'b1;
        @(negedge clk);
        rready = 1'b0; bready = 1'b0;
        n_checks++;
        if (rvalid !== 1'b0 || bvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL same_word_done: rvalid=%b bvalid=%b, required 0 0", rvalid, bvalid);
        end
        do_read(32'h40, 0, 0);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        int          len;
        for (int n = 0; n < 12; n++) begin
            addr = 32'($urandom_range(0, 32'h5FF));
            len  = $urandom_range(0, 15);
            for (int i = 0; i <= len; i++) begin
                wbuf_data[i] = $urandom;
                wbuf_strb[i] = 4'($urandom_range(0, 15));
            end
            do_write(addr, len, ($urandom_range(0, 5) == 0), $urandom_range(0, 3));
            do_read(32'($urandom_range(0, 32'h5FF)), $urandom_range(0, 15), 2);
            do_read(addr, len, $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_incr_burst();
        test_strobe();
        test_read_stall();
        test_wrap();
        test_reset_mid_burst();
        test_bresp_hold();
        test_same_word();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
